// File: rtl/riscv_pkg.sv
// Shared RV32 front-end definitions: branch funct3 codes, PC-unit state
// encoding and the default datapath width.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // Conditional-branch funct3 codes; 010 and 011 are unused and never taken.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

endpackage

// File: rtl/pc_next_unit_if.sv
// Bus between the controller/ALU (master) and the next-PC unit (slave).
//   master drives: stall, branch, jump, jalr_sel, funct3, zero, lt, ltu,
//                  pc_imm, jalr_tgt, trap_ack
//   slave drives:  pc, pc_plus4, flush, trap_pending, trap_pc, taken_count
interface pc_next_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic             branch;
    logic             jump;
    logic             jalr_sel;
    logic [2:0]       funct3;
    logic             zero;
    logic             lt;
    logic             ltu;
    logic [XLEN-1:0]  pc_imm;
    logic [XLEN-1:0]  jalr_tgt;
    logic             trap_ack;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic             flush;
    logic             trap_pending;
    logic [XLEN-1:0]  trap_pc;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output stall, branch, jump, jalr_sel, funct3, zero, lt, ltu,
               pc_imm, jalr_tgt, trap_ack,
        input  pc, pc_plus4, flush, trap_pending, trap_pc, taken_count
    );

    modport slave (
        input  stall, branch, jump, jalr_sel, funct3, zero, lt, ltu,
               pc_imm, jalr_tgt, trap_ack,
        output pc, pc_plus4, flush, trap_pending, trap_pc, taken_count
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational RV32I branch-condition decoder.
//   funct3_i           branch condition code
//   zero_i/lt_i/ltu_i  ALU flags
//   taken_c_o          condition holds (combinational)
module branch_cond_eval
    import riscv_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       lt_i,
    input  logic       ltu_i,
    output logic       taken_c_o
);

    always_comb begin
        taken_c_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_c_o = zero_i;
            F3_BNE:  taken_c_o = ~zero_i;
            F3_BLT:  taken_c_o = lt_i;
            F3_BGE:  taken_c_o = ~lt_i;
            F3_BLTU: taken_c_o = ltu_i;
            F3_BGEU: taken_c_o = ~ltu_i;
            default: taken_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selection: branches, JAL/JALR,
// stall, one-cycle flush after redirect, misaligned-target trap and a
// saturating taken-redirect counter.
//   clk_i, rst_i  clock and asynchronous active-high reset
//   bus           pc_next_unit_if slave: controller/ALU inputs in,
//                 pc / pc_plus4 (combinational) / flush / trap_pending /
//                 trap_pc / taken_count out
module pc_next_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100),
    parameter int unsigned     IALIGN   = 4,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pc_next_unit_if.slave bus
);

    // Low address bits that must be zero in a legal redirect target.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  trap_pc_q, trap_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             taken_c;
    logic             redirect_c;
    logic             misaligned_c;
    logic [XLEN-1:0]  target_c;
    logic [XLEN-1:0]  pc_plus4_c;

    branch_cond_eval u_cond (
        .funct3_i  (bus.funct3),
        .zero_i    (bus.zero),
        .lt_i      (bus.lt),
        .ltu_i     (bus.ltu),
        .taken_c_o (taken_c)
    );

    // Redirect target: jump wins over branch; JALR drops bit 0 before the alignment check.
    always_comb begin
        target_c = bus.pc_imm;
        if (bus.jump && bus.jalr_sel) begin
            target_c = {bus.jalr_tgt[XLEN-1:1], 1'b0};
        end
    end

    assign redirect_c   = bus.jump | (bus.branch & taken_c);
    assign misaligned_c = |(target_c & ALIGN_MASK);
    assign pc_plus4_c   = pc_q + XLEN'(4);

    // Next-state and register-input logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        flush_d   = 1'b0;
        trap_pc_d = trap_pc_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!bus.stall) begin
                    if (!redirect_c) begin
                        pc_d = pc_plus4_c;
                    end else if (misaligned_c) begin
                        pc_d      = TRAP_VEC;
                        trap_pc_d = target_c;
                        flush_d   = 1'b1;
                        state_d   = ST_TRAP;
                    end else begin
                        pc_d    = target_c;
                        flush_d = 1'b1;
                        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_TRAP: begin
                // PC stays at the trap vector; sequential fetch resumes after ack.
                if (bus.trap_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            flush_q   <= 1'b0;
            trap_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            flush_q   <= flush_d;
            trap_pc_q <= trap_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_plus4     = pc_plus4_c;
    assign bus.flush        = flush_q;
    assign bus.trap_pending = (state_q == ST_TRAP);
    assign bus.trap_pc      = trap_pc_q;
    assign bus.taken_count  = cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed table, counter saturation / async reset
// sequence, then randomized traffic against a reference model.
module tb_pc_next_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_next_unit_if #(.XLEN(32), .CNT_W(16)) bus0 ();
    pc_next_unit_if #(.XLEN(32), .CNT_W(2))  bus1 ();

    // Second instance sees identical inputs; only its counter width differs.
    assign bus1.stall    = bus0.stall;
    assign bus1.branch   = bus0.branch;
    assign bus1.jump     = bus0.jump;
    assign bus1.jalr_sel = bus0.jalr_sel;
    assign bus1.funct3   = bus0.funct3;
    assign bus1.zero     = bus0.zero;
    assign bus1.lt       = bus0.lt;
    assign bus1.ltu      = bus0.ltu;
    assign bus1.pc_imm   = bus0.pc_imm;
    assign bus1.jalr_tgt = bus0.jalr_tgt;
    assign bus1.trap_ack = bus0.trap_ack;

    pc_next_unit #(.XLEN(32), .CNT_W(16)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    pc_next_unit #(.XLEN(32), .CNT_W(2)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_tpc;
    bit          m_trap;
    bit          m_flush;
    int          m_cnt;

    typedef struct {
        logic        stall, branch, jump, jalr_sel;
        logic [2:0]  f3;
        logic        zero, lt, ltu;
        logic [31:0] pc_imm, jalr_tgt;
        logic        ack;
        logic [31:0] e_pc;
        logic        e_flush, e_trap;
        logic [31:0] e_tpc;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic b, input logic j, input logic js,
                                input logic [2:0] f3, input logic z, input logic l, input logic lu,
                                input logic [31:0] imm, input logic [31:0] jt, input logic ack,
                                input logic [31:0] epc, input logic ef, input logic et,
                                input logic [31:0] etpc, input int ecnt);
        vec_t v;
        v.stall = s; v.branch = b; v.jump = j; v.jalr_sel = js; v.f3 = f3;
        v.zero = z; v.lt = l; v.ltu = lu; v.pc_imm = imm; v.jalr_tgt = jt; v.ack = ack;
        v.e_pc = epc; v.e_flush = ef; v.e_trap = et; v.e_tpc = etpc; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic b, input logic j, input logic js,
                         input logic [2:0] f3, input logic z, input logic l, input logic lu,
                         input logic [31:0] imm, input logic [31:0] jt, input logic ack);
        bus0.stall = s; bus0.branch = b; bus0.jump = j; bus0.jalr_sel = js;
        bus0.funct3 = f3; bus0.zero = z; bus0.lt = l; bus0.ltu = lu;
        bus0.pc_imm = imm; bus0.jalr_tgt = jt; bus0.trap_ack = ack;
    endtask

    function automatic bit cond_taken(input logic [2:0] f3, input bit z, input bit l, input bit lu);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return l;
            3'b101:  return !l;
            3'b110:  return lu;
            3'b111:  return !lu;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [31:0] tgt;
        bit          redir;
        if (m_trap) begin
            m_flush = 1'b0;
            if (bus0.trap_ack) m_trap = 1'b0;
        end else if (bus0.stall) begin
            m_flush = 1'b0;
        end else begin
            redir = bus0.jump || (bus0.branch && cond_taken(bus0.funct3, bus0.zero, bus0.lt, bus0.ltu));
            tgt   = (bus0.jump && bus0.jalr_sel) ? (bus0.jalr_tgt & ~32'd1) : bus0.pc_imm;
            if (!redir) begin
                m_pc    = m_pc + 32'd4;
                m_flush = 1'b0;
            end else if ((tgt % 4) != 0) begin
                m_tpc   = tgt;
                m_pc    = 32'h100;
                m_trap  = 1'b1;
                m_flush = 1'b1;
            end else begin
                m_pc    = tgt;
                m_flush = 1'b1;
                m_cnt++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sat16(input int c);
        return (c > 65535) ? 16'hFFFF : 16'(c);
    endfunction

    function automatic logic [1:0] sat2(input int c);
        return (c > 3) ? 2'd3 : 2'(c);
    endfunction

    task automatic chk_model();
        chk("pc",           64'(bus0.pc),           64'(m_pc));
        chk("pc_plus4",     64'(bus0.pc_plus4),     64'(m_pc + 32'd4));
        chk("flush",        64'(bus0.flush),        64'(m_flush));
        chk("trap_pending", 64'(bus0.trap_pending), 64'(m_trap));
        chk("trap_pc",      64'(bus0.trap_pc),      64'(m_tpc));
        chk("taken_count",  64'(bus0.taken_count),  64'(sat16(m_cnt)));
        chk("taken_count2", 64'(bus1.taken_count),  64'(sat2(m_cnt)));
    endtask

    // Reset asserted away from any edge; outputs checked before the next clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_pc = 32'h0; m_tpc = 32'h0; m_trap = 1'b0; m_flush = 1'b0; m_cnt = 0;
        chk_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 0);
        do_reset();

        // stall, br, jmp, jsel, f3, z, lt, ltu, pc_imm, jalr_tgt, ack | pc, flush, trap, trap_pc, cnt
        tbl.push_back(mk(0,0,0,0,3'b000,0,0,0,32'h0,  32'h0,  0, 32'h4,   0,0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,3'b000,0,0,0,32'h0,  32'h0,  0, 32'h8,   0,0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,3'b000,0,0,0,32'h0,  32'h0,  0, 32'hC,   0,0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,3'b000,0,0,0,32'h0,  32'h0,  0, 32'h10,  0,0,32'h0,  0));
        tbl.push_back(mk(0,1,0,0,3'b001,0,0,0,32'h40, 32'h0,  0, 32'h40,  1,0,32'h0,  1));
        tbl.push_back(mk(0,1,0,0,3'b001,1,0,0,32'h40, 32'h0,  0, 32'h44,  0,0,32'h0,  1));
        tbl.push_back(mk(0,0,1,1,3'b000,0,0,0,32'h0,  32'h205,0, 32'h204, 1,0,32'h0,  2));
        tbl.push_back(mk(0,0,0,0,3'b000,0,0,0,32'h0,  32'h0,  0, 32'h208, 0,0,32'h0,  2));
        tbl.push_back(mk(0,0,1,1,3'b000,0,0,0,32'h0,  32'h206,0, 32'h100, 1,1,32'h206,2));
        tbl.push_back(mk(1,1,0,0,3'b000,1,0,0,32'h40, 32'h0,  0, 32'h100, 0,1,32'h206,2));
        tbl.push_back(mk(0,0,1,0,3'b000,0,0,0,32'h80, 32'h0,  0, 32'h100, 0,1,32'h206,2));
        tbl.push_back(mk(1,0,1,1,3'b000,0,0,0,32'h0,  32'h300,0, 32'h100, 0,1,32'h206,2));
        tbl.push_back(mk(0,1,0,0,3'b001,0,0,0,32'h48, 32'h0,  0, 32'h100, 0,1,32'h206,2));
        tbl.push_back(mk(0,0,1,0,3'b000,0,0,0,32'h88, 32'h0,  0, 32'h100, 0,1,32'h206,2));
        tbl.push_back(mk(0,0,0,0,3'b000,0,0,0,32'h0,  32'h0,  1, 32'h100, 0,0,32'h206,2));
        tbl.push_back(mk(0,0,0,0,3'b000,0,0,0,32'h0,  32'h0,  0, 32'h104, 0,0,32'h206,2));
        tbl.push_back(mk(1,1,0,0,3'b000,1,0,0,32'h80, 32'h0,  0, 32'h104, 0,0,32'h206,2));
        tbl.push_back(mk(0,1,0,0,3'b000,1,0,0,32'h80, 32'h0,  0, 32'h80,  1,0,32'h206,3));
        tbl.push_back(mk(0,0,0,0,3'b000,0,0,0,32'h0,  32'h0,  1, 32'h84,  0,0,32'h206,3));
        tbl.push_back(mk(0,0,1,0,3'b000,0,0,0,32'h1000,32'h0, 0, 32'h1000,1,0,32'h206,4));
        tbl.push_back(mk(0,1,0,0,3'b010,1,0,0,32'h40, 32'h0,  0, 32'h1004,0,0,32'h206,4));
        tbl.push_back(mk(0,1,0,0,3'b100,0,1,0,32'h2000,32'h0, 0, 32'h2000,1,0,32'h206,5));
        tbl.push_back(mk(0,1,0,0,3'b101,0,1,0,32'h3000,32'h0, 0, 32'h2004,0,0,32'h206,5));
        tbl.push_back(mk(0,1,0,0,3'b110,0,0,0,32'h3000,32'h0, 0, 32'h2008,0,0,32'h206,5));
        tbl.push_back(mk(0,1,0,0,3'b111,0,0,0,32'h3000,32'h0, 0, 32'h3000,1,0,32'h206,6));
        tbl.push_back(mk(0,1,1,1,3'b000,1,0,0,32'h500, 32'h900,0, 32'h900, 1,0,32'h206,7));
        tbl.push_back(mk(0,0,1,0,3'b000,0,0,0,32'h102, 32'h0,  0, 32'h100, 1,1,32'h102,7));
        tbl.push_back(mk(0,0,0,0,3'b000,0,0,0,32'h0,   32'h0,  1, 32'h100, 0,0,32'h102,7));
        tbl.push_back(mk(0,0,0,0,3'b000,0,0,0,32'h0,   32'h0,  0, 32'h104, 0,0,32'h102,7));

        foreach (tbl[i]) begin
            drive(tbl[i].stall, tbl[i].branch, tbl[i].jump, tbl[i].jalr_sel, tbl[i].f3,
                  tbl[i].zero, tbl[i].lt, tbl[i].ltu, tbl[i].pc_imm, tbl[i].jalr_tgt, tbl[i].ack);
            tick();
            chk("tbl_pc",       64'(bus0.pc),           64'(tbl[i].e_pc));
            chk("tbl_pc_plus4", 64'(bus0.pc_plus4),     64'(tbl[i].e_pc + 32'd4));
            chk("tbl_flush",    64'(bus0.flush),        64'(tbl[i].e_flush));
            chk("tbl_trap",     64'(bus0.trap_pending), 64'(tbl[i].e_trap));
            chk("tbl_trap_pc",  64'(bus0.trap_pc),      64'(tbl[i].e_tpc));
            chk("tbl_cnt",      64'(bus0.taken_count),  64'(tbl[i].e_cnt));
            chk("tbl_cnt2",     64'(bus1.taken_count),  64'(sat2(tbl[i].e_cnt)));
        end

        // Counter saturation on the narrow instance, then reset while trapped.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(0, 1, 0, 0, 3'b000, 1, 0, 0, 32'(k * 32'h40), 32'h0, 0);
            tick();
            chk("sat_cnt2", 64'(bus1.taken_count), 64'((k > 3) ? 3 : k));
            chk("sat_cnt",  64'(bus0.taken_count), 64'(k));
        end
        drive(0, 0, 1, 0, 3'b000, 0, 0, 0, 32'h2001, 32'h0, 0);
        tick();
        chk_model();
        chk("pre_rst_trap", 64'(bus0.trap_pending), 64'(1));
        do_reset();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] imm, jt;
            if (($urandom % 400) == 0) begin
                do_reset();
            end else begin
                imm = $urandom;
                if (($urandom % 10) != 0) imm[1:0] = 2'b00;
                jt = $urandom;
                if (($urandom % 8) != 0) jt[1] = 1'b0;
                drive(($urandom % 5) == 0, ($urandom % 2) == 0, ($urandom % 6) == 0,
                      ($urandom % 2) == 0, 3'($urandom), ($urandom % 2) == 0,
                      ($urandom % 2) == 0, ($urandom % 2) == 0, imm, jt,
                      ($urandom % 4) == 0);
                tick();
                chk_model();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised successor to the datapath's branch-and-zero next-PC multiplexer.
- Owns the program-counter register. Resolves all RV32I conditional branches from ALU flags, plus JAL and JALR.
- Adds stall, a one-cycle pipeline flush on redirect, a misaligned-target trap state machine, and a saturating taken-redirect counter.
- Sits between the controller/ALU and the instruction memory address port.

Parameters:
- XLEN, 32, width of PC and all address buses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned taken target.
- IALIGN, 4, instruction alignment in bytes. Legal values are 2 and 4.
- CNT_W, 16, width of the taken-redirect counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC; no state update this cycle.
- branch  in  1  controller: current instruction is a conditional branch.
- jump  in  1  controller: current instruction is JAL or JALR.
- jalr_sel  in  1  with jump=1: 1 selects JALR, 0 selects JAL.
- funct3  in  3  branch condition code.
- zero  in  1  ALU result equal to zero.
- lt  in  1  ALU signed less-than.
- ltu  in  1  ALU unsigned less-than.
- pc_imm  in  XLEN  PC + immediate, the branch/JAL target.
- jalr_tgt  in  XLEN  rs1 + immediate from the ALU.
- trap_ack  in  1  trap handler acknowledge.
- pc  out  XLEN  current PC (registered).
- pc_plus4  out  XLEN  pc + 4, combinational, for link write-back.
- flush  out  1  registered one-cycle pulse after any redirect.
- trap_pending  out  1  high while in TRAP state.
- trap_pc  out  XLEN  captured offending target address.
- taken_count  out  CNT_W  saturating count of taken redirects.

Behaviour:
- Reset (async, active-high): pc=RESET_PC, flush=0, trap_pending=0, trap_pc=0, taken_count=0, state=RUN. Reset asserted mid-operation aborts everything immediately.

Branch condition decode (funct3):
- 000 BEQ: taken when zero.
- 001 BNE: taken when !zero.
- 100 BLT: taken when lt.
- 101 BGE: taken when !lt.
- 110 BLTU: taken when ltu.
- 111 BGEU: taken when !ltu.
- 010 and 011: never taken.

Target selection and priority:
- jump=1 has priority over branch.
- JALR target is jalr_tgt with bit 0 forced to 0.
- JAL target is pc_imm.
- A taken branch targets pc_imm.
- Otherwise the next PC is pc+4 (modulo 2^XLEN, wraps silently).

Misalignment:
- A redirect target is misaligned when target[1:0]!=0 (IALIGN=4) or target[0]!=0 (IALIGN=2). For JALR this is checked after bit 0 is cleared.
- Sequential pc+4 is never checked.

State machine: RUN, TRAP.
- RUN, stall=1: pc, counter and state hold; flush is driven to 0.
- RUN, no redirect: pc <= pc+4.
- RUN, aligned redirect: pc <= target; flush=1 for the next cycle; taken_count increments.
- RUN, misaligned redirect: pc <= TRAP_VEC; trap_pc <= target; trap_pending=1; flush=1; state -> TRAP; counter unchanged.
- TRAP: pc frozen at TRAP_VEC; branch, jump and stall are ignored; flush=0.
- TRAP -> RUN on trap_ack=1: trap_pending clears next edge, pc resumes sequential fetch from TRAP_VEC+4 on the following edges.
- trap_ack in RUN is ignored.

Counter and latency:
- taken_count saturates at all ones and does not wrap.
- Latency: one clock from redirect decision to the new pc; flush coincides with the new pc.

Decomposition:
- Shared package `riscv_pkg` holds:
  - funct3 branch localparams (F3_BEQ...F3_BGEU);
  - state encoding (ST_RUN, ST_TRAP);
  - default XLEN.
- One natural sub-module: `branch_cond_eval`, a combinational funct3+flags -> taken decoder, reused later by the ALU compare path.
- Everything else stays in pc_next_unit.

Test Plan:
- Reset then 3 idle cycles -> pc = 0x0, 0x4, 0x8, 0xC; flush=0; taken_count=0.
- pc=0x10, branch=1, funct3=001, zero=0, pc_imm=0x40 -> next pc=0x40, flush=1 for one cycle, taken_count=1. Same with zero=1 -> pc=0x14, flush=0.
- jump=1, jalr_sel=1, jalr_tgt=0x0000_0205 -> pc=0x204, flush=1. Same with jalr_tgt=0x0000_0206 (IALIGN=4) -> pc=0x100, trap_pending=1, trap_pc=0x206.
- In TRAP: hold trap_ack=0 for 5 cycles with branch/jump toggling -> pc stays 0x100. Then trap_ack=1 -> trap_pending=0, then pc=0x104.
- stall=1 coinciding with a taken BEQ -> pc unchanged, flush=0, counter unchanged. Release stall with inputs held -> redirect occurs.
- CNT_W=2, five aligned taken branches -> taken_count 1,2,3,3,3. Assert reset mid-stream -> all outputs return to reset values asynchronously.
